dcache_fill_ctrl: RTL

Miss/write-through controller sitting directly downstream of the 2-way data cache, between it and main memory. On a cache read miss it fetches the aligned 64-bit block from memory, waits a fixed memory latency, then drives `din_mem` and pulses `countdone` so the cache installs the line. On every store it forwards the word to memory (write-through). The pipeline is stalled for the duration of both operations.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/mem_lat_counter.sv | 39 +++
 rtl/dcache_fill_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared data-memory definitions: fill FSM states, block geometry and
// address alignment helpers used by the data- and instruction-side fill paths.
package dmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_FILL    = 3'd2,
        ST_RECHECK = 3'd3,
        ST_WR_WAIT = 3'd4
    } fill_state_e;

    // 64-bit block: 3 byte-offset bits; bit 2 selects the 32-bit word
    localparam int BLOCK_OFFSET_W = 3;
    localparam int WORD_SEL       = 2;

    // Helpers operate on the widest supported address; callers cast
    localparam int ADDR_MAX_W = 64;

    // Clear the byte offset inside a 64-bit block
    function automatic logic [ADDR_MAX_W-1:0] block_align(input logic [ADDR_MAX_W-1:0] a);
        logic [ADDR_MAX_W-1:0] r;
        r = a;
        r[BLOCK_OFFSET_W-1:0] = '0;
        return r;
    endfunction

    // Clear the byte offset inside a 32-bit word
    function automatic logic [ADDR_MAX_W-1:0] word_align(input logic [ADDR_MAX_W-1:0] a);
        logic [ADDR_MAX_W-1:0] r;
        r = a;
        r[WORD_SEL-1:0] = '0;
        return r;
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Memory latency counter: loads LATENCY-1, counts down to zero and holds there.
module mem_lat_counter #(
    parameter int LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, decrement saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/dcache_fill_ctrl.sv
// Data-cache miss fill and write-through controller. Fetches a 64-bit block
// on a load miss, forwards every store to memory, and stalls the pipeline
// while either is in flight.
module dcache_fill_ctrl
    import dmem_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          wren,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   din_pipe,
    input  logic          hit_miss,
    output logic          stall,
    output logic [63:0]   din_mem,
    output logic          countdone,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [31:0]   mem_wdata,
    input  logic [63:0]   mem_rdata
);

    fill_state_e   state_q,     state_d;
    logic [63:0]   din_mem_q,   din_mem_d;
    logic          countdone_q, countdone_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic          mem_rd_q,    mem_rd_d;
    logic          mem_wr_q,    mem_wr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;

    mem_lat_counter #(
        .LATENCY(LATENCY)
    ) u_lat_cnt (
        .clk (clk),
        .rst (rst),
        .load(cnt_load),
        .dec (cnt_dec),
        .zero(cnt_zero)
    );

    // Next state and next registered outputs; strobes default low so each
    // lasts exactly one cycle, address/data registers hold between accesses
    always_comb begin
        state_d     = state_q;
        din_mem_d   = din_mem_q;
        countdone_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Stores take priority; load hits need no memory traffic
                if (req_valid && wren) begin
                    state_d     = ST_WR_WAIT;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = AW'(word_align(ADDR_MAX_W'(addr)));
                    mem_wdata_d = din_pipe;
                    cnt_load    = 1'b1;
                end else if (req_valid && !hit_miss) begin
                    state_d    = ST_RD_WAIT;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = AW'(block_align(ADDR_MAX_W'(addr)));
                    cnt_load   = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_zero) begin
                    din_mem_d   = mem_rdata;
                    countdone_d = 1'b1;
                    state_d     = ST_FILL;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_FILL: begin
                state_d = ST_RECHECK;
            end
            ST_RECHECK: begin
                // Gives the cache one cycle to re-register hit_miss for the new line
                state_d = ST_IDLE;
            end
            ST_WR_WAIT: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            din_mem_q   <= '0;
            countdone_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            din_mem_q   <= din_mem_d;
            countdone_q <= countdone_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Stall is combinational so the detect cycle itself freezes the pipeline
    always_comb begin
        stall = 1'b1;
        if (state_q == ST_IDLE) begin
            stall = req_valid && (wren || !hit_miss);
        end
    end

    assign din_mem   = din_mem_q;
    assign countdone = countdone_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
